// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM states, active-low hex font and blank code for seg_scan_ctrl
package seg_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_BLANK,
    ST_ON,
    ST_OFF
  } seg_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // gfedcba, active-low; element [n] is the glyph for nibble n
  localparam logic [15:0][6:0] FONT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg_hex_font.sv
// rtl/seg_hex_font.sv - combinational nibble to active-low gfedcba glyph lookup
module seg_hex_font
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg7
);

  assign o_seg7 = FONT[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - N-digit multiplexed 7-segment scanner; optional blink via SEG_SCAN_BLINK_EN
// Outputs are registered from next-cycle counter/state values so node and segment change together.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 16384,
  parameter int BLANK_CYCLES = 64,
  parameter int DIM_W        = 4
`ifdef SEG_SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
)
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [4*NUM_DIGITS-1:0]   i_digit,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic [NUM_DIGITS-1:0]     i_digit_en,
  input  logic                      i_lz_blank,
  input  logic [DIM_W-1:0]          i_brightness,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]     i_blink,
`endif
  output logic [NUM_DIGITS-1:0]     o_node,
  output logic [7:0]                o_segment,
  output logic                      o_frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int P_W   = CNT_W + DIM_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [P_W-1:0]   ACT      = P_W'(SCAN_DIV - BLANK_CYCLES);
  localparam logic [P_W-1:0]   BLK      = P_W'(BLANK_CYCLES);

  seg_state_e r_state, w_state_nx;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]        r_idx, w_idx_nx;
  logic [4*NUM_DIGITS-1:0] r_snap_digit, w_src_digit;
  logic [NUM_DIGITS-1:0]   r_snap_dp, r_snap_en, w_src_dp, w_src_en, w_lit;
  logic                    r_snap_lz, w_src_lz;
  logic [DIM_W-1:0]        r_snap_bri, w_src_bri;
  logic [NUM_DIGITS-1:0]   r_node;
  logic [7:0]              r_segment;
  logic                    r_frame_done;
  logic                    w_wrap, w_loading, w_show, w_frame_end;
  logic [P_W-1:0]          w_prod, w_on_end, w_cnt_ext;
  logic [3:0]              w_nib;
  logic [6:0]              w_font;

  assign w_wrap      = (r_cnt == CNT_LAST);
  assign w_frame_end = w_wrap && (r_idx == IDX_LAST);
  assign w_cnt_nx    = w_wrap ? '0 : r_cnt + CNT_W'(1);
  assign w_idx_nx    = !w_wrap ? r_idx : ((r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1));

  // During LOAD the snapshot is being written this edge, so look through to the inputs
  assign w_loading   = (r_state == ST_LOAD);
  assign w_src_digit = w_loading ? i_digit      : r_snap_digit;
  assign w_src_dp    = w_loading ? i_dp         : r_snap_dp;
  assign w_src_en    = w_loading ? i_digit_en   : r_snap_en;
  assign w_src_lz    = w_loading ? i_lz_blank   : r_snap_lz;
  assign w_src_bri   = w_loading ? i_brightness : r_snap_bri;

  assign w_prod    = ACT * (P_W'(w_src_bri) + P_W'(1));
  assign w_on_end  = BLK + (w_prod >> DIM_W);
  assign w_cnt_ext = P_W'(w_cnt_nx);

`ifdef SEG_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0]       r_frame_cnt;
  logic                  r_hide;
  logic [NUM_DIGITS-1:0] r_snap_blink, w_src_blink;

  assign w_src_blink = w_loading ? i_blink : r_snap_blink;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_cnt  <= '0;
      r_hide       <= 1'b0;
      r_snap_blink <= '0;
    end else begin
      if (w_loading) r_snap_blink <= i_blink;
      if (w_frame_end) begin
        if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_hide      <= ~r_hide;
        end else begin
          r_frame_cnt <= r_frame_cnt + FC_W'(1);
        end
      end
    end
  end
`endif

  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    w_lit    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (w_src_digit[4*i +: 4] == 4'd0);
      w_lit[i] = w_src_en[i] && !(w_src_lz && (i > 0) && zero_run);
    end
`ifdef SEG_SCAN_BLINK_EN
    w_lit = w_lit & ~(w_src_blink & {NUM_DIGITS{r_hide}});
`endif
  end

  always_comb begin
    w_state_nx = ST_OFF;
    if (w_cnt_nx == '0)
      w_state_nx = (w_idx_nx == '0) ? ST_LOAD : ST_BLANK;
    else if (w_cnt_ext < BLK)
      w_state_nx = ST_BLANK;
    else if (w_cnt_ext < w_on_end)
      w_state_nx = ST_ON;
  end

  assign w_nib  = w_src_digit[{w_idx_nx, 2'b00} +: 4];
  assign w_show = (w_state_nx == ST_ON) && w_lit[w_idx_nx];

  seg_hex_font u_font (
    .i_nibble (w_nib),
    .o_seg7   (w_font)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_LOAD;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_snap_digit <= '0;
      r_snap_dp    <= '0;
      r_snap_en    <= '0;
      r_snap_lz    <= 1'b0;
      r_snap_bri   <= '0;
      r_node       <= '1;
      r_segment    <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_idx <= w_idx_nx;
      if (w_loading) begin
        r_snap_digit <= i_digit;
        r_snap_dp    <= i_dp;
        r_snap_en    <= i_digit_en;
        r_snap_lz    <= i_lz_blank;
        r_snap_bri   <= i_brightness;
      end
      r_node       <= w_show ? ~(NUM_DIGITS'(1) << w_idx_nx) : '1;
      r_segment    <= w_show ? {~w_src_dp[w_idx_nx], w_font} : SEG_OFF;
      r_frame_done <= (w_cnt_nx == CNT_LAST) && (w_idx_nx == IDX_LAST);
    end
  end

  assign o_node       = r_node;
  assign o_segment    = r_segment;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl against a frame-arithmetic model
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BC = 2;
  localparam int DW = 2;
  localparam int FRAME = ND * SD;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digit = 16'h12AF;
  logic [3:0]  dp = 4'b0010;
  logic [3:0]  en = 4'hF;
  logic        lz = 1'b0;
  logic [1:0]  bri = 2'd3;
  logic [3:0]  blink = 4'b0000;
  logic [3:0]  node;
  logic [7:0]  seg;
  logic        fd;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC),
    .DIM_W        (DW)
`ifdef SEG_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_digit      (digit),
    .i_dp         (dp),
    .i_digit_en   (en),
    .i_lz_blank   (lz),
    .i_brightness (bri),
`ifdef SEG_SCAN_BLINK_EN
    .i_blink      (blink),
`endif
    .o_node       (node),
    .o_segment    (seg),
    .o_frame_done (fd)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] font7(input logic [3:0] n);
    case (n)
      4'h0: font7 = 7'b1000000;  4'h1: font7 = 7'b1111001;
      4'h2: font7 = 7'b0100100;  4'h3: font7 = 7'b0110000;
      4'h4: font7 = 7'b0011001;  4'h5: font7 = 7'b0010010;
      4'h6: font7 = 7'b0000010;  4'h7: font7 = 7'b1111000;
      4'h8: font7 = 7'b0000000;  4'h9: font7 = 7'b0010000;
      4'hA: font7 = 7'b0001000;  4'hB: font7 = 7'b0000011;
      4'hC: font7 = 7'b1000110;  4'hD: font7 = 7'b0100001;
      4'hE: font7 = 7'b0000110;  default: font7 = 7'b0001110;
    endcase
  endfunction

  // Model: cycle number t since reset release, frame-start snapshot, frame count
  int          t = 0;
  int          frames = 0;
  bit          valid = 1'b0;
  logic [15:0] s_digit = '0;
  logic [3:0]  s_dp = '0, s_en = '0, s_blink = '0;
  logic        s_lz = 1'b0;
  logic [1:0]  s_bri = '0;

  always @(posedge clk) begin
    if (rst) begin
      t <= 0; frames <= 0; valid <= 1'b1;
      s_digit <= '0; s_dp <= '0; s_en <= '0; s_lz <= 1'b0; s_bri <= '0; s_blink <= '0;
    end else begin
      if (t % FRAME == 0) begin
        s_digit <= digit; s_dp <= dp; s_en <= en; s_lz <= lz; s_bri <= bri; s_blink <= blink;
      end
      if (t % FRAME == FRAME - 1) frames <= frames + 1;
      t <= t + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int cnt, slot, onl;
    logic lit;
    logic [3:0] e_node;
    logic [7:0] e_seg;
    if (valid) begin
      cnt  = t % SD;
      slot = (t % FRAME) / SD;
      onl  = ((SD - BC) * (int'(s_bri) + 1)) >> DW;
      lit  = s_en[slot] && !(s_lz && slot > 0 && (s_digit >> (4 * slot)) == 16'h0);
`ifdef SEG_SCAN_BLINK_EN
      if (s_blink[slot] && ((frames / BF) % 2 == 1)) lit = 1'b0;
`endif
      e_node = 4'hF;
      e_seg  = 8'hFF;
      if (lit && cnt >= BC && cnt < BC + onl) begin
        e_node = 4'hF ^ (4'b0001 << slot);
        e_seg  = {~s_dp[slot], font7(s_digit[4*slot +: 4])};
      end
      chk("model_node", 32'(node), 32'(e_node));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_fd", 32'(fd), 32'(t % FRAME == FRAME - 1));
    end
  end

  task automatic check_at(input int tt, input logic [3:0] e_node, input logic [7:0] e_seg,
                          input logic e_fd, input string nm);
    bit hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (t == tt) begin hit = 1'b1; break; end
    end
    if (!hit) begin
      chk({nm, "_timeout"}, 32'(t), 32'(tt));
    end else begin
      chk({nm, "_node"}, 32'(node), 32'(e_node));
      chk({nm, "_seg"}, 32'(seg), 32'(e_seg));
      chk({nm, "_fd"}, 32'(fd), 32'(e_fd));
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_at(2,   4'b1110, 8'b10001110, 1'b0, "t2_s0c2");
    check_at(15,  4'b1110, 8'b10001110, 1'b0, "t2_s0c15");
    check_at(16,  4'b1111, 8'hFF,       1'b0, "t2_s1c0");
    check_at(18,  4'b1101, 8'b00001000, 1'b0, "t2_s1c2");
    check_at(63,  4'b0111, 8'b11111001, 1'b1, "t2_fd63");
    check_at(64,  4'b1111, 8'hFF,       1'b0, "t2_t64");
    check_at(127, 4'b0111, 8'b11111001, 1'b1, "t2_fd127");
    step; bri = 2'd0;
    check_at(130, 4'b1110, 8'b10001110, 1'b0, "t3_c2");
    check_at(132, 4'b1110, 8'b10001110, 1'b0, "t3_c4");
    check_at(133, 4'b1111, 8'hFF,       1'b0, "t3_c5");
    step; digit = 16'h0050; lz = 1'b1; dp = 4'b0000; bri = 2'd3;
    check_at(194, 4'b1110, 8'b11000000, 1'b0, "t4_s0");
    check_at(210, 4'b1101, 8'b10010010, 1'b0, "t4_s1");
    check_at(226, 4'b1111, 8'hFF,       1'b0, "t4_s2");
    check_at(242, 4'b1111, 8'hFF,       1'b0, "t4_s3");
    step; digit = 16'h0000;
    check_at(258, 4'b1110, 8'b11000000, 1'b0, "t4z_s0");
    check_at(274, 4'b1111, 8'hFF,       1'b0, "t4z_s1");
    step; digit = 16'h1111; lz = 1'b0;
    check_at(338, 4'b1101, 8'b11111001, 1'b0, "t5_s1");
    step; digit = 16'h2222;
    check_at(370, 4'b0111, 8'b11111001, 1'b0, "t5_s3_old");
    check_at(385, 4'b1111, 8'hFF,       1'b0, "t5_next_c1");
    check_at(386, 4'b1110, 8'b10100100, 1'b0, "t5_next_c2");
    step; en = 4'b0101;
    check_at(450, 4'b1110, 8'b10100100, 1'b0, "t6_s0");
    check_at(466, 4'b1111, 8'hFF,       1'b0, "t6_s1");
    check_at(482, 4'b1011, 8'b10100100, 1'b0, "t6_s2");
    check_at(498, 4'b1111, 8'hFF,       1'b0, "t6_s3");
    check_at(517, 4'b1110, 8'b10100100, 1'b0, "t1_preon");
    step; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t1_rst_node", 32'(node), 32'(4'b1111));
    chk("t1_rst_seg", 32'(seg), 32'(8'hFF));
    chk("t1_rst_fd", 32'(fd), 32'(1'b0));
    step; step; rst = 1'b0;
    check_at(1, 4'b1111, 8'hFF,       1'b0, "t1_rel_c1");
    check_at(2, 4'b1110, 8'b10100100, 1'b0, "t1_rel_c2");

    for (int it = 0; it < 60; it++) begin
      step;
      digit = 16'($urandom);
      if ($urandom_range(0, 1) == 1) digit = digit >> (4 * $urandom_range(1, 4));
      dp    = 4'($urandom);
      en    = 4'($urandom);
      lz    = 1'($urandom);
      bri   = 2'($urandom);
      blink = 4'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) step;
        rst = 1'b0;
      end
      repeat ($urandom_range(10, 150)) @(posedge clk);
    end

`ifdef SEG_SCAN_BLINK_EN
    step; rst = 1'b1; digit = 16'h1234; dp = 4'b0000; en = 4'hF; lz = 1'b0; bri = 2'd3;
    blink = 4'b0001;
    step; step; rst = 1'b0;
    check_at(2,   4'b1110, 8'b10011001, 1'b0, "bl_f0");
    check_at(66,  4'b1110, 8'b10011001, 1'b0, "bl_f1");
    check_at(130, 4'b1111, 8'hFF,       1'b0, "bl_f2");
    check_at(146, 4'b1101, 8'b10110000, 1'b0, "bl_f2s1");
    check_at(194, 4'b1111, 8'hFF,       1'b0, "bl_f3");
    check_at(258, 4'b1110, 8'b10011001, 1'b0, "bl_f4");
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display driver for N digits, generalising the fixed 4-digit hex scanner. It adds:
- frame-coherent input capture
- per-digit enable and decimal point
- leading-zero blanking
- anti-ghosting dead time between digits
- PWM brightness control

It sits between register/debug logic and board anode/segment pins. All outputs are registered.

Parameters:
NUM_DIGITS, 4, number of digits/anodes (1..8)
SCAN_DIV, 16384, clk cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 64, dead-time cycles at start of every slot, all anodes off (>=1)
DIM_W, 4, brightness input width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
digit  in  4*NUM_DIGITS  hex nibbles, digit i = digit[4i+3:4i], digit 0 rightmost
dp  in  NUM_DIGITS  decimal point per digit, 1=lit
digit_en  in  NUM_DIGITS  1=digit may light
lz_blank  in  1  leading-zero blanking enable
brightness  in  DIM_W  duty level, 0=dimmest, all-ones=full
node  out  NUM_DIGITS  anode select, active-low, at most one bit low
segment  out  8  active-low; [7]=dp, [6:0]=g..a
frame_done  out  1  one-cycle pulse on last cycle of each frame

Behaviour:
Clock and reset:
- One clock (clk); synchronous active-high reset (rst).
- Reset values: node all 1s, segment 8'hFF, frame_done 0, slot counter 0, digit index 0, snapshot registers 0, FSM=LOAD.

Counters:
- Slot counter slot_cnt counts 0..SCAN_DIV-1, then wraps.
- On wrap, index advances i -> i+1; NUM_DIGITS-1 wraps to 0.
- frame_done=1 in the cycle slot_cnt==SCAN_DIV-1 and index==NUM_DIGITS-1.

FSM (states LOAD, BLANK, ON, OFF):
- LOAD: only at slot_cnt 0 of index 0. Captures digit, dp, digit_en, lz_blank and brightness into snapshot registers. node off. Next state BLANK.
- BLANK: slot_cnt < BLANK_CYCLES; node all 1s, segment 8'hFF. Entered at slot_cnt 0 of every index other than 0.
- ON: BLANK_CYCLES <= slot_cnt < BLANK_CYCLES+on_len, with the digit lit.
- OFF: remainder of the slot; node all 1s, segment 8'hFF.
- Slot wrap goes to LOAD if the next index is 0, otherwise BLANK.

Brightness arithmetic:
- ACT = SCAN_DIV - BLANK_CYCLES.
- on_len = (ACT*(b+1)) >> DIM_W, using the snapshot b; compute at full product width, no overflow.
- If on_len==0, ON is skipped.

Lighting rules:
- Digit i lights only if digit_en[i]=1 and it is not LZ-blanked.
- LZ-blanked: lz_blank=1, digit i>0, and digits i..NUM_DIGITS-1 are all zero. Digit 0 is never LZ-blanked.
- An unlit digit keeps node all 1s for the whole slot.
- Lit digit drives node[i]=0 and all other node bits 1.
- Lit segment = {~dp[i], font(digit i)}, with node and segment updating on the same edge (no one-cycle code lag).

Boundary conditions:
- Inputs changing mid-frame take effect only at the next LOAD.
- rst mid-slot forces reset values on the next edge, and the FSM restarts at LOAD, index 0.

Font (gfedcba, active-low):
0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Optional Feature:
SEG_SCAN_BLINK_EN:
- Adds input blink [NUM_DIGITS] and parameter BLINK_FRAMES (default 32).
- A frame counter toggles a blink phase every BLINK_FRAMES frames; the phase resets to "visible".
- In the hidden phase, snapshot digits with blink[i]=1 are treated as unlit.
- blink is captured at LOAD.
- Without the macro: no port, no counter, identical behaviour otherwise.

Decomposition:
- Package seg_pkg: FSM state enum typedef; 16-entry active-low font constant; SEG_OFF=8'hFF.
- One sub-module seg_hex_font: combinational nibble-to-7-bit lookup using the package constant.

Test Plan:
(All with NUM_DIGITS=4, SCAN_DIV=16, BLANK_CYCLES=2, DIM_W=2; frame = 64 cycles.)
1. Reset: rst=1 for 3 cycles mid-ON -> next edge node=4'b1111, segment=8'hFF, frame_done=0; after release, digit 0 lights at slot_cnt 2.
2. digit=16'h12AF, dp=4'b0010, digit_en=4'hF, lz_blank=0, brightness=3 -> on_len=14. Slot0 cycles 2..15: node=1110, segment=8'b10001110. Slot1: node=1101, segment=8'b00001000. frame_done pulses at cycles 63, 127.
3. brightness=0 -> on_len=(14*1)>>2=3; each digit lit only at slot_cnt 2..4, dark at 0..1 and 5..15.
4. Leading zeros: digit=16'h0050, lz_blank=1 -> slots 3,2 node=1111; slot1 segment=8'b10010010; slot0 segment=8'b11000000. With digit=16'h0000, only slot0 is lit.
5. Capture coherence: change digit 16'h1111 -> 16'h2222 during slot 1 -> "1" shown through end of frame; "2" first appears at slot0 cycle 2 of the next frame.
6. digit_en=4'b0101 -> slots 1,3 dark, slots 0,2 lit. (SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, blink=4'b0001: digit 0 dark in frames 2-3, lit in frames 0-1, 4-5.)
